// File: rtl/mem_sum_master.sv
// mem_sum_master: reads count words from base, sums them, writes the sum to dest.
// Define MEM_SUM_SATURATE_EN to saturate the accumulator instead of wrapping.
module mem_sum_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    input  logic [ADDR_W-1:0] dest_addr,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    localparam logic [ADDR_W-1:0] ONE = 1;
    state_t state, state_n;
    logic [ADDR_W-1:0] remaining, remaining_n, dest, dest_n, mem_address_n;
    logic [DATA_W-1:0] acc, acc_n, sum, mem_wdata_n, result_n;
    logic [DATA_W:0] raw;
    logic mem_write_en_n, busy_n, done_n;
    assign raw = {1'b0, acc} + {1'b0, mem_rdata};
`ifdef MEM_SUM_SATURATE_EN
    assign sum = raw[DATA_W] ? '1 : raw[DATA_W-1:0];
`else
    assign sum = raw[DATA_W-1:0];
`endif
    always_comb begin
        state_n = state;
        remaining_n = remaining;
        dest_n = dest;
        acc_n = acc;
        mem_address_n = mem_address;
        mem_write_en_n = 1'b0;
        mem_wdata_n = '0;
        busy_n = busy;
        done_n = 1'b0;
        result_n = result;
        case (state)
            IDLE: if (start) begin
                dest_n = dest_addr;
                remaining_n = count;
                acc_n = '0;
                mem_address_n = base_addr;
                busy_n = 1'b1;
                state_n = (count == '0) ? WRITE : READ;
            end
            READ: begin
                acc_n = sum;
                mem_address_n = mem_address + ONE;
                remaining_n = remaining - ONE;
                state_n = (remaining == ONE) ? WRITE : READ;
            end
            // First WRITE cycle presents the strobe; the second retires it.
            WRITE: if (!mem_write_en) begin
                mem_address_n = dest;
                mem_wdata_n = acc;
                mem_write_en_n = 1'b1;
            end else begin
                result_n = acc;
                done_n = 1'b1;
                busy_n = 1'b0;
                state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            remaining <= '0;
            dest <= '0;
            acc <= '0;
            mem_address <= '0;
            mem_write_en <= 1'b0;
            mem_wdata <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            remaining <= remaining_n;
            dest <= dest_n;
            acc <= acc_n;
            mem_address <= mem_address_n;
            mem_write_en <= mem_write_en_n;
            mem_wdata <= mem_wdata_n;
            busy <= busy_n;
            done <= done_n;
            result <= result_n;
        end
    end
endmodule

// File: tb/tb_mem_sum_master.sv
// tb_mem_sum_master: table-driven check of mem_sum_master against a 1024x16 memory model.
module tb_mem_sum_master;
    logic clk = 1'b0;
    logic rst, start, mem_write_en, busy, done;
    logic [9:0] base_addr, count, dest_addr, mem_address;
    logic [15:0] mem_wdata, mem_rdata, result;
    logic [15:0] mem [1024];
    logic [9:0] addr_seq [16];
    int checks = 0, failures = 0, wr_cnt = 0, done_cnt = 0, lat;

    typedef struct {
        logic [9:0] base, cnt, dest;
        logic [15:0] exp;
        int lat;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;

    mem_sum_master dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
        .dest_addr(dest_addr), .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .done(done), .result(result)
    );

    assign mem_rdata = mem[mem_address];
    always @(negedge clk) begin
        if (mem_write_en) begin
            mem[mem_address] <= mem_wdata;
            wr_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [9:0] b, input logic [9:0] c, input logic [9:0] d, output int cyc);
        base_addr = b;
        count = c;
        dest_addr = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = 10'h3FF;
        count = 10'h3FF;
        dest_addr = 10'h3FF;
        cyc = 1;
        while (!done && cyc < 2000) begin
            if (cyc <= 16) addr_seq[cyc-1] = mem_address;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        dest_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 10; i++) mem[500+i] = 16'(i + 1);
        mem[700] = 16'h1234;
        mem[1022] = 16'd1;
        mem[1023] = 16'd2;
        mem[0] = 16'd4;
        mem[10] = 16'hFFFF;
        mem[11] = 16'h0002;
        mem[20] = 16'd100;
        mem[21] = 16'd200;
        mem[22] = 16'd300;
        mem[23] = 16'd400;
        vecs[0] = '{10'd500, 10'd10, 10'd600, 16'd55, 13};
        vecs[1] = '{10'd1, 10'd0, 10'd700, 16'd0, 3};
        vecs[2] = '{10'd1022, 10'd3, 10'd800, 16'd7, 6};
`ifdef MEM_SUM_SATURATE_EN
        vecs[3] = '{10'd10, 10'd2, 10'd900, 16'hFFFF, 5};
`else
        vecs[3] = '{10'd10, 10'd2, 10'd900, 16'h0001, 5};
`endif
        vecs[4] = '{10'd20, 10'd4, 10'd20, 16'd1000, 7};
        repeat (2) @(posedge clk);
        #1;
        check("reset_addr", 32'(mem_address), 0);
        check("reset_we", 32'(mem_write_en), 0);
        check("reset_wdata", 32'(mem_wdata), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", 32'(result), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            wr_cnt = 0;
            run(vecs[v].base, vecs[v].cnt, vecs[v].dest, lat);
            check($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
            check($sformatf("v%0d_result", v), 32'(result), 32'(vecs[v].exp));
            check($sformatf("v%0d_mem_dest", v), 32'(mem[vecs[v].dest]), 32'(vecs[v].exp));
            check($sformatf("v%0d_writes", v), 32'(wr_cnt), 1);
            check($sformatf("v%0d_busy_at_done", v), 32'(busy), 0);
            if (vecs[v].cnt != 0) check($sformatf("v%0d_first_addr", v), 32'(addr_seq[0]), 32'(vecs[v].base));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", v), 32'(done), 0);
            check($sformatf("v%0d_result_hold", v), 32'(result), 32'(vecs[v].exp));
            check($sformatf("v%0d_wdata_idle", v), 32'(mem_wdata), 0);
            if (v == 2) begin
                check("wrap_addr0", 32'(addr_seq[0]), 1022);
                check("wrap_addr1", 32'(addr_seq[1]), 1023);
                check("wrap_addr2", 32'(addr_seq[2]), 0);
            end
        end

        // Reset during the fourth READ cycle aborts with no writeback.
        mem[600] = 16'hBEEF;
        wr_cnt = 0;
        done_cnt = 0;
        base_addr = 10'd500;
        count = 10'd10;
        dest_addr = 10'd600;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_we", 32'(mem_write_en), 0);
        check("abort_result", 32'(result), 0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 0);
        check("abort_no_write", 32'(wr_cnt), 0);
        check("abort_mem600", 32'(mem[600]), 32'hBEEF);

        // Starts during busy and during DONE are both ignored.
        wr_cnt = 0;
        done_cnt = 0;
        base_addr = 10'd500;
        count = 10'd10;
        dest_addr = 10'd600;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        repeat (3) @(posedge clk);
        #1;
        lat += 3;
        base_addr = 10'd10;
        count = 10'd2;
        dest_addr = 10'd900;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat++;
        while (!done && lat < 2000) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("busy_start_latency", 32'(lat), 13);
        check("busy_start_result", 32'(result), 55);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_start_busy", 32'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        check("busy_start_done_cnt", 32'(done_cnt), 1);
        check("busy_start_writes", 32'(wr_cnt), 1);
        check("busy_start_mem600", 32'(mem[600]), 55);
        check("busy_start_result_hold", 32'(result), 55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
